axis_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that merges NUM_INPUTS AXI-stream sources onto one output stream. It sits in front of a shared stream consumer. A grant is held for a whole packet, delimited by ilast. The output goes through an internal two-entry register stage, so iready never depends combinationally on oready.

---
 rtl/axis_rr_arbiter_pkg.sv | 19 +
 rtl/axis_rr_select.sv | 34 +++
 rtl/axis_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the packet-aware round-robin stream arbiter:
// arbiter state encoding, output-stage depth and an index-width helper.
package axis_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam logic [1:0] STAGE_DEPTH = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Rotating priority scan: first requesting input at or after ptr, modulo
// NUM_INPUTS, so non-power-of-two input counts wrap correctly.
module axis_rr_select
  import axis_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [NUM_INPUTS-1:0]  ivalid,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [INDEX_WIDTH-1:0] sel,
  output logic                   found
);

  int                  w_idx;
  logic [NUM_INPUTS-1:0] w_shift;

  always_comb begin
    sel     = '0;
    found   = 1'b0;
    w_idx   = 0;
    w_shift = '0;
    // Walk from farthest to nearest so the closest request to ptr wins.
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      w_idx   = (int'(ptr) + i) % NUM_INPUTS;
      w_shift = ivalid >> w_idx;
      if (w_shift[0]) begin
        sel   = INDEX_WIDTH'(w_idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Merges NUM_INPUTS AXI-stream sources onto one stream, holding each grant
// for a whole packet, behind a two-entry output stage that decouples oready.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] idata,
  input  logic [NUM_INPUTS-1:0]            ivalid,
  input  logic [NUM_INPUTS-1:0]            ilast,
  output logic [NUM_INPUTS-1:0]            iready,
  output logic [DATA_WIDTH-1:0]            odata,
  output logic                             olast,
  output logic                             ovalid,
  input  logic                             oready,
  output logic [INDEX_WIDTH-1:0]           ogrant,
  output logic [1:0]                       size
);

  generate
    if (clog2(NUM_INPUTS) != INDEX_WIDTH) begin : g_bad_index_width
      $error("INDEX_WIDTH must equal clog2(NUM_INPUTS)");
    end
  endgenerate

  arb_state_t             r_state, w_state_next;
  logic [INDEX_WIDTH-1:0] r_grant, w_grant_next;
  logic [INDEX_WIDTH-1:0] r_ptr, w_ptr_next;
  logic [INDEX_WIDTH-1:0] w_sel, w_cur;
  logic                   w_found, w_req, w_space, w_push, w_pop;
  logic                   w_in_last, w_wr_slot;
  logic [DATA_WIDTH-1:0]  w_in_data;
  logic [DATA_WIDTH-1:0]  w_lane [NUM_INPUTS];

  logic [DATA_WIDTH-1:0]  r_data [2];
  logic                   r_last [2];
  logic [INDEX_WIDTH-1:0] r_idx  [2];
  logic [1:0]             r_size;

  function automatic logic [INDEX_WIDTH-1:0] next_index(input logic [INDEX_WIDTH-1:0] g);
    return (g == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0 : g + 1'b1;
  endfunction

  axis_rr_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_select (
    .ivalid(ivalid),
    .ptr   (r_ptr),
    .sel   (w_sel),
    .found (w_found)
  );

  // While locked the granted input keeps ready even through ivalid gaps.
  assign w_cur   = (r_state == ST_LOCKED) ? r_grant : w_sel;
  assign w_req   = (r_state == ST_LOCKED) | w_found;
  assign w_space = (r_size != STAGE_DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      assign w_lane[gi] = idata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign iready[gi] = w_req & w_space & (w_cur == INDEX_WIDTH'(gi));
    end
  endgenerate

  assign w_in_data = w_lane[w_cur];
  assign w_in_last = ilast[w_cur];
  assign w_push    = |(ivalid & iready);
  assign w_pop     = (r_size != 2'd0) & oready;
  // Slot 0 is the head; a push lands behind whatever survives this cycle.
  assign w_wr_slot = r_size[0] & ~w_pop;

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          if (w_in_last) begin
            w_ptr_next = next_index(w_cur);
          end else begin
            w_state_next = ST_LOCKED;
            w_grant_next = w_cur;
          end
        end
      end
      ST_LOCKED: begin
        if (w_push && w_in_last) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = next_index(r_grant);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_size <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
        r_idx[i]  <= '0;
      end
    end else begin
      if (w_pop) begin
        r_data[0] <= r_data[1];
        r_last[0] <= r_last[1];
        r_idx[0]  <= r_idx[1];
      end
      if (w_push) begin
        r_data[w_wr_slot] <= w_in_data;
        r_last[w_wr_slot] <= w_in_last;
        r_idx[w_wr_slot]  <= w_cur;
      end
      r_size <= r_size + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign odata  = r_data[0];
  assign olast  = r_last[0];
  assign ogrant = r_idx[0];
  assign ovalid = (r_size != 2'd0);
  assign size   = r_size;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a 4-input instance for reset,
// round-robin, packet lock, backpressure and reset mid-packet, plus a
// 3-input instance for pointer wrap-around.
module tb_axis_rr_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic [31:0] idata;
  logic [3:0]  ivalid, ilast, iready;
  logic [7:0]  odata;
  logic        olast, ovalid, oready;
  logic [1:0]  ogrant, size;

  logic [23:0] idata3;
  logic [2:0]  ivalid3, ilast3, iready3;
  logic [7:0]  odata3;
  logic        olast3, ovalid3, oready3;
  logic [1:0]  ogrant3, size3;

  int passed = 0;
  int total  = 0;

  axis_rr_arbiter #(.NUM_INPUTS(4), .INDEX_WIDTH(2), .DATA_WIDTH(8)) u_dut (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid),
    .ilast(ilast), .iready(iready), .odata(odata), .olast(olast),
    .ovalid(ovalid), .oready(oready), .ogrant(ogrant), .size(size)
  );

  axis_rr_arbiter #(.NUM_INPUTS(3), .INDEX_WIDTH(2), .DATA_WIDTH(8)) u_dut3 (
    .clock(clock), .resetn(resetn), .idata(idata3), .ivalid(ivalid3),
    .ilast(ilast3), .iready(iready3), .odata(odata3), .olast(olast3),
    .ovalid(ovalid3), .oready(oready3), .ogrant(ogrant3), .size(size3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_beat(input int k, input logic [7:0] d, input logic l);
    idata[k*8 +: 8] = d;
    ilast[k]        = l;
  endtask

  initial begin
    resetn  = 1'b0;
    idata   = '0;
    ivalid  = '0;
    ilast   = '0;
    oready  = 1'b0;
    idata3  = '0;
    ivalid3 = '0;
    ilast3  = '0;
    oready3 = 1'b1;

    // Reset state
    tick;
    tick;
    chk("reset_ovalid", 32'(ovalid), 0);
    chk("reset_olast",  32'(olast),  0);
    chk("reset_odata",  32'(odata),  0);
    chk("reset_ogrant", 32'(ogrant), 0);
    chk("reset_size",   32'(size),   0);
    chk("reset_iready", 32'(iready), 0);
    chk("reset_size3",  32'(size3),  0);
    chk("reset_olast3", 32'(olast3), 0);
    $display("reset: ovalid=%0d size=%0d", ovalid, size);

    // Round-robin over single-beat packets 0xA0..0xA3
    resetn = 1'b1;
    oready = 1'b1;
    for (int k = 0; k < 4; k++) set_beat(k, 8'hA0 + 8'(k), 1'b1);
    ivalid = 4'b1111;
    #1;
    chk("rr_first_iready", 32'(iready), 'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_ovalid", 32'(ovalid), 1);
      chk("rr_odata",  32'(odata),  'hA0 + (i % 4));
      chk("rr_ogrant", 32'(ogrant), i % 4);
      chk("rr_size",   32'(size),   1);
      chk("rr_iready", 32'(iready), 1 << ((i + 1) % 4));
      $display("rr beat %0d: odata=%0h ogrant=%0d", i, odata, ogrant);
    end
    ivalid = 4'b0000;
    tick;
    chk("rr_drain_ovalid", 32'(ovalid), 0);

    // Packet lock on input 2 with an ivalid gap; input 0 always valid
    set_beat(0, 8'h50, 1'b1);
    set_beat(2, 8'h10, 1'b0);
    ivalid = 4'b0101;
    #1;
    chk("lock_start_iready", 32'(iready), 'h4);
    tick;
    set_beat(2, 8'h11, 1'b0);
    #1;
    chk("lock_b0_odata",  32'(odata),  'h10);
    chk("lock_b0_olast",  32'(olast),  0);
    chk("lock_b0_ogrant", 32'(ogrant), 2);
    chk("lock_b0_iready", 32'(iready), 'h4);
    $display("lock beat0: odata=%0h iready=%b", odata, iready);
    tick;
    ivalid = 4'b0001;
    #1;
    chk("lock_b1_odata",  32'(odata),  'h11);
    chk("lock_gap_iready", 32'(iready), 'h4);
    tick;
    chk("lock_gap1_ovalid", 32'(ovalid), 0);
    chk("lock_gap1_iready", 32'(iready), 'h4);
    tick;
    chk("lock_gap2_iready", 32'(iready), 'h4);
    set_beat(2, 8'h12, 1'b1);
    ivalid = 4'b0101;
    tick;
    chk("lock_b2_odata",  32'(odata),  'h12);
    chk("lock_b2_olast",  32'(olast),  1);
    chk("lock_after_iready", 32'(iready), 'h1);
    $display("lock beat2: odata=%0h olast=%0d", odata, olast);
    tick;
    chk("lock_next_odata",  32'(odata),  'h50);
    chk("lock_next_ogrant", 32'(ogrant), 0);
    ivalid = 4'b0000;
    tick;

    // Backpressure with input 0 streaming single-beat packets
    oready = 1'b0;
    set_beat(0, 8'h60, 1'b1);
    ivalid = 4'b0001;
    #1;
    chk("bp_iready0", 32'(iready), 'h1);
    tick;
    set_beat(0, 8'h61, 1'b1);
    #1;
    chk("bp_size1",  32'(size),  1);
    chk("bp_odata1", 32'(odata), 'h60);
    tick;
    set_beat(0, 8'h62, 1'b1);
    #1;
    chk("bp_size2",   32'(size),   2);
    chk("bp_full_iready", 32'(iready), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_size",   32'(size),   2);
      chk("bp_hold_odata",  32'(odata),  'h60);
      chk("bp_hold_iready", 32'(iready), 0);
      $display("bp hold %0d: odata=%0h size=%0d", i, odata, size);
    end
    oready = 1'b1;
    tick;
    chk("bp_drain_odata",  32'(odata),  'h61);
    chk("bp_drain_size",   32'(size),   1);
    chk("bp_drain_iready", 32'(iready), 'h1);
    tick;
    set_beat(0, 8'h63, 1'b1);
    #1;
    chk("bp_resume_odata", 32'(odata), 'h62);
    chk("bp_resume_size",  32'(size),  1);
    tick;
    chk("pushpop_odata", 32'(odata), 'h63);
    chk("pushpop_size",  32'(size),  1);
    $display("push/pop: odata=%0h size=%0d", odata, size);
    ivalid = 4'b0000;
    tick;
    chk("bp_empty_size", 32'(size), 0);

    // Reset in the middle of a 4-beat packet from input 1
    set_beat(1, 8'h70, 1'b0);
    ivalid = 4'b0010;
    tick;
    set_beat(1, 8'h71, 1'b0);
    tick;
    set_beat(1, 8'h72, 1'b0);
    set_beat(0, 8'h80, 1'b1);
    ivalid = 4'b0011;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    #1;
    chk("midrst_size",   32'(size),   0);
    chk("midrst_ovalid", 32'(ovalid), 0);
    chk("midrst_iready", 32'(iready), 'h1);
    tick;
    chk("midrst_odata",  32'(odata),  'h80);
    chk("midrst_ogrant", 32'(ogrant), 0);
    $display("mid-packet reset: next odata=%0h ogrant=%0d", odata, ogrant);
    ivalid = 4'b0000;
    tick;

    // Three inputs: pointer wraps from 2 back to 0
    ilast3 = 3'b111;
    idata3[16 +: 8] = 8'h22;
    ivalid3 = 3'b100;
    #1;
    chk("n3_iready_first", 32'(iready3), 'h4);
    tick;
    idata3[0 +: 8] = 8'h30;
    idata3[8 +: 8] = 8'h31;
    ivalid3 = 3'b011;
    #1;
    chk("n3_odata_a",  32'(odata3),  'h22);
    chk("n3_ogrant_a", 32'(ogrant3), 2);
    chk("n3_wrap_iready", 32'(iready3), 'h1);
    tick;
    ivalid3 = 3'b101;
    #1;
    chk("n3_odata_b",  32'(odata3),  'h30);
    chk("n3_ogrant_b", 32'(ogrant3), 0);
    chk("n3_iready_b", 32'(iready3), 'h4);
    tick;
    chk("n3_ogrant_c", 32'(ogrant3), 2);
    chk("n3_iready_c", 32'(iready3), 'h1);
    tick;
    chk("n3_ogrant_d", 32'(ogrant3), 0);
    chk("n3_ovalid_d", 32'(ovalid3), 1);
    $display("n3: ogrant=%0d size=%0d", ogrant3, size3);
    ivalid3 = 3'b000;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
